inter_rr: RTL and testbench

//  Parametrised N-master / M-slave interconnect, successor to the 2x2 fixed-priority version.

---
 rtl/inter_rr.sv | 126 ++++++++++++
 tb/tb_inter_rr.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inter_rr.sv
// N-master / M-slave request interconnect: one buffered word per master,
// round-robin arbitration, registered valid/ready delivery and completion pulse.
`timescale 1ns/1ps
module inter_rr #(
    parameter  int NUM_MASTER = 4,
    parameter  int NUM_SLAVE  = 2,
    parameter  int ADDR_W     = 3,
    parameter  int VAL_W      = 3,
    localparam int SEL_W      = $clog2(NUM_SLAVE),
    localparam int DATA_W     = SEL_W + ADDR_W + VAL_W,
    localparam int GID_W      = $clog2(NUM_MASTER)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_MASTER-1:0]        in_valid,
    input  logic [NUM_MASTER*DATA_W-1:0] data_in,
    output logic [NUM_MASTER-1:0]        in_ready,
    input  logic [NUM_SLAVE-1:0]         ready_slave,
    output logic [NUM_SLAVE-1:0]         valid_slave,
    output logic [ADDR_W-1:0]            addr_out,
    output logic [VAL_W-1:0]             value_out,
    output logic [NUM_SLAVE-1:0]         handshake_slave,
    output logic [GID_W-1:0]             grant_id
);

    // state | meaning
    // IDLE  | no transfer presented; arbitrate among pending masters
    // SEND  | word of master grant_id presented to its slave, waiting for ready
    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state_q, state_d;
    logic [NUM_MASTER-1:0]   pending_q, pending_d, set_m, clr_m;
    logic [DATA_W-1:0]       word_q [NUM_MASTER];
    logic [GID_W-1:0]        last_q, last_d, gid_d, pick;
    logic [NUM_SLAVE-1:0]    valid_d, hs_d;
    logic [ADDR_W-1:0]       addr_d;
    logic [VAL_W-1:0]        value_d;
    logic [DATA_W-1:0]       pick_word;
    logic [SEL_W-1:0]        pick_sel;
    logic                    found, fire;
    int                      arb_idx;

    assign in_ready  = ~pending_q;
    assign set_m     = in_valid & ~pending_q;
    assign pick_word = word_q[pick];
    assign pick_sel  = pick_word[DATA_W-1 -: SEL_W];
    assign fire      = |(valid_slave & ready_slave);

    // Search starts just after the last served master, so it ranks lowest.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        arb_idx = 0;
        for (int k = 1; k <= NUM_MASTER; k++) begin
            arb_idx = (int'(last_q) + k) % NUM_MASTER;
            if (!found && pending_q[arb_idx]) begin
                found = 1'b1;
                pick  = GID_W'(arb_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        valid_d = valid_slave;
        addr_d  = addr_out;
        value_d = value_out;
        gid_d   = grant_id;
        hs_d    = '0;
        clr_m   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = SEND;
                    gid_d   = pick;
                    valid_d = NUM_SLAVE'(1) << pick_sel;
                    addr_d  = pick_word[VAL_W +: ADDR_W];
                    value_d = pick_word[VAL_W-1:0];
                end
            end
            SEND: begin
                if (fire) begin
                    state_d         = IDLE;
                    clr_m[grant_id] = 1'b1;
                    last_d          = grant_id;
                    valid_d         = '0;
                    addr_d          = '0;
                    value_d         = '0;
                    gid_d           = '0;
                    hs_d            = valid_slave;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pending_d = (pending_q | set_m) & ~clr_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            pending_q       <= '0;
            last_q          <= GID_W'(NUM_MASTER - 1);
            valid_slave     <= '0;
            addr_out        <= '0;
            value_out       <= '0;
            handshake_slave <= '0;
            grant_id        <= '0;
            for (int i = 0; i < NUM_MASTER; i++) word_q[i] <= '0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            last_q          <= last_d;
            valid_slave     <= valid_d;
            addr_out        <= addr_d;
            value_out       <= value_d;
            handshake_slave <= hs_d;
            grant_id        <= gid_d;
            for (int i = 0; i < NUM_MASTER; i++) begin
                if (set_m[i]) word_q[i] <= data_in[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_inter_rr.sv
// Bench for inter_rr: transfer-level reference model feeding a scoreboard,
// directed scenarios followed by a randomized phase.
`timescale 1ns/1ps
module tb_inter_rr;
    localparam int NM = 4, NS = 2, AW = 3, VW = 3, SW = 1, DW = SW + AW + VW, GW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     in_valid;
    logic [NM*DW-1:0]  data_in;
    logic [NM-1:0]     in_ready;
    logic [NS-1:0]     ready_slave;
    logic [NS-1:0]     valid_slave;
    logic [AW-1:0]     addr_out;
    logic [VW-1:0]     value_out;
    logic [NS-1:0]     handshake_slave;
    logic [GW-1:0]     grant_id;

    always #5 clk = ~clk;

    inter_rr #(.NUM_MASTER(NM), .NUM_SLAVE(NS), .ADDR_W(AW), .VAL_W(VW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
        .in_ready(in_ready), .ready_slave(ready_slave), .valid_slave(valid_slave),
        .addr_out(addr_out), .value_out(value_out), .handshake_slave(handshake_slave),
        .grant_id(grant_id)
    );

    int n_cmp = 0, n_err = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sel_of(logic [DW-1:0] w); return int'(w[DW-1 -: SW]); endfunction
    function automatic int addr_of(logic [DW-1:0] w); return int'(w[VW +: AW]); endfunction
    function automatic int val_of(logic [DW-1:0] w); return int'(w[VW-1:0]); endfunction
    function automatic logic [DW-1:0] mk(int s, int a, int v);
        return DW'((s << (AW + VW)) | (a << VW) | v);
    endfunction

    // Reference model: one slot per master, round-robin pick from last+1.
    typedef struct { int g; int sel; int addr; int val; } xfer_t;
    xfer_t           sb[$];
    bit              m_pend[NM];
    bit              m_old[NM];
    logic [DW-1:0]   m_word[NM];
    int              m_last, m_g, m_s, m_idx;
    bit              m_busy, m_found;
    logic [NS-1:0]   m_hs;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NM; i++) m_pend[i] = 1'b0;
            m_last = NM - 1;
            m_busy = 1'b0;
            m_g    = 0;
            m_hs   = '0;
            sb.delete();
        end else begin
            m_old = m_pend;
            m_hs  = '0;
            if (m_busy) begin
                m_s = sel_of(m_word[m_g]);
                if (ready_slave[m_s]) begin
                    m_hs         = NS'(1) << m_s;
                    m_pend[m_g]  = 1'b0;
                    m_last       = m_g;
                    m_busy       = 1'b0;
                end
            end else begin
                m_found = 1'b0;
                for (int k = 1; k <= NM; k++) begin
                    m_idx = (m_last + k) % NM;
                    if (!m_found && m_pend[m_idx]) begin
                        m_found = 1'b1;
                        m_busy  = 1'b1;
                        m_g     = m_idx;
                        sb.push_back('{m_idx, sel_of(m_word[m_idx]), addr_of(m_word[m_idx]),
                                       val_of(m_word[m_idx])});
                    end
                end
            end
            for (int i = 0; i < NM; i++) begin
                if (in_valid[i] && !m_old[i]) begin
                    m_pend[i] = 1'b1;
                    m_word[i] = data_in[i*DW +: DW];
                end
            end
        end
    end

    // Monitor: per-cycle output checks plus scoreboard pop on each new transfer.
    logic [NS-1:0] prev_v, exp_v;
    logic [AW-1:0] prev_a;
    logic [VW-1:0] prev_d;
    logic [NM-1:0] exp_rdy;
    int            hs_cnt = 0, last_addr = -1, last_val = -1;
    int            gnt_log[$];
    xfer_t         x;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = '0;
        end else begin
            exp_v = m_busy ? NS'(NS'(1) << sel_of(m_word[m_g])) : '0;
            for (int i = 0; i < NM; i++) exp_rdy[i] = !m_pend[i];
            chk("valid_slave", 32'(valid_slave), 32'(exp_v));
            chk("handshake_slave", 32'(handshake_slave), 32'(m_hs));
            chk("grant_id", 32'(grant_id), m_busy ? 32'(m_g) : 32'd0);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (handshake_slave != '0) hs_cnt++;
            if (valid_slave != '0 && prev_v == '0) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    x = sb.pop_front();
                    chk("xfer_grant", 32'(grant_id), 32'(x.g));
                    chk("xfer_valid", 32'(valid_slave), 32'(NS'(1) << x.sel));
                    chk("xfer_addr", 32'(addr_out), 32'(x.addr));
                    chk("xfer_value", 32'(value_out), 32'(x.val));
                end
                gnt_log.push_back(int'(grant_id));
                last_addr = int'(addr_out);
                last_val  = int'(value_out);
            end else if (valid_slave != '0) begin
                chk("hold_addr", 32'(addr_out), 32'(prev_a));
                chk("hold_value", 32'(value_out), 32'(prev_d));
            end else begin
                chk("idle_addr", 32'(addr_out), 32'd0);
                chk("idle_value", 32'(value_out), 32'd0);
            end
            prev_v = valid_slave;
            prev_a = addr_out;
            prev_d = value_out;
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic post(int m, int s, int a, int v);
        in_valid[m]           = 1'b1;
        data_in[m*DW +: DW]   = mk(s, a, v);
    endtask

    task automatic wait_valid(string name, int budget);
        int c = 0;
        while (valid_slave == '0 && c < budget) begin
            tick(1);
            c++;
        end
        chk(name, 32'(valid_slave != '0), 32'd1);
    endtask

    int h0, c;
    bit busy_any;

    initial begin
        rst_n = 1'b0; in_valid = '0; data_in = '0; ready_slave = '0;
        #2;
        chk("rst_valid", 32'(valid_slave), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'hF);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_hs", 32'(handshake_slave), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // reset mid-SEND
        post(0, 0, 4, 6); tick(1); in_valid = '0;
        wait_valid("t1_wait", 10);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_valid", 32'(valid_slave), 32'd0);
        chk("t1_addr", 32'(addr_out), 32'd0);
        chk("t1_value", 32'(value_out), 32'd0);
        chk("t1_grant", 32'(grant_id), 32'd0);
        chk("t1_in_ready", 32'(in_ready), 32'hF);
        tick(1);
        rst_n = 1'b1;
        ready_slave = 2'b11;
        h0 = hs_cnt;
        tick(5);
        chk("t1_no_hs", 32'(hs_cnt - h0), 32'd0);

        // single transfer
        ready_slave = 2'b10;
        post(0, 1, 5, 3); tick(1); in_valid = '0;
        chk("t2_lat0", 32'(valid_slave), 32'd0);
        tick(1);
        chk("t2_valid", 32'(valid_slave), 32'b10);
        chk("t2_addr", 32'(addr_out), 32'd5);
        chk("t2_value", 32'(value_out), 32'd3);
        tick(1);
        chk("t2_hs", 32'(handshake_slave), 32'b10);
        tick(1);
        chk("t2_hs_once", 32'(handshake_slave), 32'd0);

        // backpressure
        ready_slave = 2'b00;
        post(1, 0, 6, 2); tick(1); in_valid = '0;
        wait_valid("t3_wait", 10);
        h0 = hs_cnt;
        tick(10);
        chk("t3_held", 32'(valid_slave), 32'b01);
        ready_slave = 2'b01;
        tick(3);
        chk("t3_one_hs", 32'(hs_cnt - h0), 32'd1);

        // hold/drop while pending
        ready_slave = 2'b00;
        post(2, 1, 2, 4); tick(1); in_valid = '0; tick(2);
        post(2, 0, 7, 7); tick(1); in_valid = '0; tick(2);
        post(2, 0, 3, 3); tick(1); in_valid = '0;
        ready_slave = 2'b11;
        tick(4);
        chk("t5_addr", 32'(last_addr), 32'd2);
        chk("t5_value", 32'(last_val), 32'd4);

        // ready on the wrong slave
        ready_slave = 2'b10;
        post(3, 0, 1, 7); tick(1); in_valid = '0;
        wait_valid("t6_wait", 10);
        h0 = hs_cnt;
        tick(5);
        chk("t6_no_hs", 32'(hs_cnt - h0), 32'd0);
        chk("t6_held", 32'(valid_slave), 32'b01);
        ready_slave = 2'b01;
        tick(3);
        chk("t6_hs", 32'(hs_cnt - h0), 32'd1);

        // round-robin with repost by m0
        ready_slave = 2'b11;
        gnt_log.delete();
        post(0, 0, 1, 1); post(1, 1, 2, 2); post(2, 0, 3, 3); post(3, 1, 4, 4);
        tick(1); in_valid = '0;
        c = 0;
        while (gnt_log.size() < 2 && c < 20) begin tick(1); c++; end
        chk("t4_wait2", 32'(gnt_log.size() >= 2), 32'd1);
        post(0, 1, 6, 5); tick(1); in_valid = '0;
        c = 0;
        while (gnt_log.size() < 5 && c < 40) begin tick(1); c++; end
        chk("t4_wait5", 32'(gnt_log.size() >= 5), 32'd1);
        if (gnt_log.size() >= 5) begin
            chk("t4_g0", 32'(gnt_log[0]), 32'd0);
            chk("t4_g1", 32'(gnt_log[1]), 32'd1);
            chk("t4_g2", 32'(gnt_log[2]), 32'd2);
            chk("t4_g3", 32'(gnt_log[3]), 32'd3);
            chk("t4_g4", 32'(gnt_log[4]), 32'd0);
        end

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            in_valid    = NM'($urandom) & NM'($urandom);
            data_in     = (NM*DW)'($urandom);
            ready_slave = NS'($urandom);
            tick(1);
        end

        in_valid = '0;
        ready_slave = 2'b11;
        c = 0;
        busy_any = 1'b1;
        while (busy_any && c < 200) begin
            tick(1);
            c++;
            busy_any = m_busy;
            for (int i = 0; i < NM; i++) busy_any |= m_pend[i];
        end
        chk("drain", 32'(busy_any), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
